// File: rtl/picorv32_bench_pkg.sv
// Shared types and helpers for the picorv32 bench memory responder.
package picorv32_bench_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic logic [WAIT_W-1:0] clamp_wait(input logic [WAIT_W-1:0] cfg,
                                                     input logic [WAIT_W-1:0] max_wait);
        return (cfg > max_wait) ? max_wait : cfg;
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Word-wide storage with four byte-lane write enables and a registered read port.
// The read register loads zero whenever no read is requested.
module mem_byte_ram #(
    parameter int MEM_WORDS = 1024,
    parameter int INIT_ZERO = 1
) (
    input  logic                         clk,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [3:0]                   we,
    input  logic [31:0]                  wdata,
    input  logic                         rd_en,
    output logic [31:0]                  rdata
);

    localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

    logic [31:0] mem [MEM_WORDS] = '{default: INIT_WORD};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= rd_en ? mem[addr] : 32'h0000_0000;
    end

endmodule

// File: rtl/picorv32_mem_responder.sv
// picorv32 native-bus slave memory with bounded wait states and a sticky address-error flag.
// Define MEM_PROTOCOL_CHECK_EN to compile in bus protocol assertions.
module picorv32_mem_responder
    import picorv32_bench_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int MAX_WAIT  = 4,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic [3:0]  wait_cfg,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        addr_err
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] n_req;
    logic              in_range;
    logic              misaligned;
    logic              is_write;
    logic              enter_ack;
    logic              ram_rd;
    logic [3:0]        ram_we;
    logic [AW-1:0]     word_idx;

    always_comb begin
        n_req      = clamp_wait(wait_cfg, MAX_WAIT_C);
        in_range   = (mem_addr[31:AW+2] == '0);
        misaligned = |mem_addr[1:0];
        is_write   = |mem_wstrb;
        word_idx   = mem_addr[AW+1:2];
        // The access itself happens on the edge that moves the FSM into ACK.
        enter_ack  = resetn && mem_valid &&
                     (((state == IDLE) && (n_req == '0)) ||
                      ((state == WAIT) && (cnt == WAIT_W'(1))));
        ram_rd     = enter_ack && !is_write && in_range;
        ram_we     = (enter_ack && in_range) ? mem_wstrb : 4'b0000;
    end

    mem_byte_ram #(
        .MEM_WORDS(MEM_WORDS),
        .INIT_ZERO(INIT_ZERO)
    ) u_ram (
        .clk  (clk),
        .addr (word_idx),
        .we   (ram_we),
        .wdata(mem_wdata),
        .rd_en(ram_rd),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_ready <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            mem_ready <= enter_ack;
            if (enter_ack && (!in_range || misaligned)) begin
                addr_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        if (n_req == '0) begin
                            state <= ACK;
                        end else begin
                            cnt   <= n_req;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!mem_valid) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                        if (cnt == WAIT_W'(1)) begin
                            state <= ACK;
                        end
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_PROTOCOL_CHECK_EN
    state_t      prev_state;
    logic        prev_ready;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic        acc_instr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_state <= IDLE;
            prev_ready <= 1'b0;
        end else begin
            prev_state <= state;
            prev_ready <= mem_ready;
        end
        if (state == IDLE && mem_valid) begin
            acc_addr  <= mem_addr;
            acc_wdata <= mem_wdata;
            acc_wstrb <= mem_wstrb;
            acc_instr <= mem_instr;
        end
        if (resetn) begin
            if (state == WAIT) begin
                assert (mem_valid) else $error("mem_valid dropped while waiting");
                assert (mem_addr == acc_addr && mem_wdata == acc_wdata &&
                        mem_wstrb == acc_wstrb && mem_instr == acc_instr)
                    else $error("request fields changed before acknowledge");
            end
            assert (!(mem_ready && prev_ready)) else $error("mem_ready high two cycles");
            if (mem_ready) begin
                assert (prev_state == IDLE || prev_state == WAIT)
                    else $error("mem_ready not preceded by IDLE or WAIT");
            end
        end
    end
`else
    // mem_instr carries no behaviour in this model.
    logic unused_instr;
    assign unused_instr = mem_instr;
`endif

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Randomized bench for picorv32_mem_responder against a word-array reference model.
module tb_picorv32_mem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [3:0]  wait_cfg;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        addr_err;

    always #5 clk = ~clk;

    picorv32_mem_responder #(
        .MEM_WORDS(1024),
        .MAX_WAIT (4),
        .INIT_ZERO(1)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .wait_cfg (wait_cfg),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .addr_err (addr_err)
    );

    logic [31:0] model [1024];
    bit          err_model;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_in_range(input logic [31:0] addr);
        return (addr >> 2) < 1024;
    endfunction

    // Caller is at #1 after a rising edge.
    task automatic do_reset(input int cycles);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        resetn    = 1'b1;
        err_model = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [3:0] cfg);
        int          n;
        int          k;
        bit          seen;
        logic [31:0] exp;
        n = (cfg > 4) ? 4 : int'(cfg);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        wait_cfg  = cfg;
        mem_instr = 1'($urandom);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            wait_cfg = 4'($urandom);
            if (mem_ready) seen = 1'b1;
        end
        check_eq({tag, " latency"}, 32'(k), 32'(n + 1));
        exp = 32'h0;
        if (model_in_range(addr)) begin
            if (wstrb == 4'b0000) begin
                exp = model[addr[11:2]];
            end else begin
                for (int i = 0; i < 4; i++)
                    if (wstrb[i]) model[addr[11:2]][8*i +: 8] = wdata[8*i +: 8];
            end
        end
        if (addr[1:0] != 2'b00 || !model_in_range(addr)) err_model = 1'b1;
        if (seen) begin
            check_eq({tag, " rdata"}, mem_rdata, exp);
            check_eq({tag, " addr_err"}, 32'(addr_err), 32'(err_model));
        end
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, " ready_drop"}, {mem_ready, mem_rdata}, 33'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        int          r;
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        wait_cfg  = 4'h0;
        @(posedge clk);
        #1;
        do_reset(3);
        check_eq("reset ready", 32'(mem_ready), 32'h0);
        check_eq("reset rdata", mem_rdata, 32'h0);
        check_eq("reset addr_err", 32'(addr_err), 32'h0);

        txn("rd10", 32'h0000_0010, 32'h0, 4'b0000, 4'd0);
        txn("wr20", 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111, 4'd3);
        txn("rd20", 32'h0000_0020, 32'h0, 4'b0000, 4'd1);
        txn("wr20b", 32'h0000_0020, 32'h0000_00AA, 4'b0001, 4'd2);
        txn("rd20b", 32'h0000_0020, 32'h0, 4'b0000, 4'd0);
        check_eq("byte merge", model[8], 32'hDEAD_BEAA);
        txn("clamp", 32'h0000_0020, 32'h0, 4'b0000, 4'd15);
        txn("oor_rd", 32'h0000_1000, 32'h0, 4'b0000, 4'd1);
        txn("sticky", 32'h0000_0020, 32'h0, 4'b0000, 4'd0);
        txn("oor_wr", 32'h0000_1000, 32'h1234_5678, 4'b1111, 4'd0);
        txn("alias0", 32'h0000_0000, 32'h0, 4'b0000, 4'd2);

        do_reset(1);
        check_eq("err_clear", 32'(addr_err), 32'h0);
        txn("mis_rd", 32'h0000_0022, 32'h0, 4'b0000, 4'd1);

        // Reset during WAIT with valid held long enough to have completed.
        do_reset(1);
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0020;
        mem_wdata = 32'h5555_5555;
        mem_wstrb = 4'b1111;
        wait_cfg  = 4'd2;
        @(posedge clk);
        #1;
        check_eq("rstw wait", 32'(mem_ready), 32'h0);
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("rstw noack", 32'(mem_ready), 32'h0);
        end
        mem_valid = 1'b0;
        resetn    = 1'b1;
        err_model = 1'b0;
        @(posedge clk);
        #1;
        txn("rstw rd", 32'h0000_0020, 32'h0, 4'b0000, 4'd0);

        // Abandoned write: valid drops during WAIT.
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0024;
        mem_wdata = 32'h1234_5678;
        mem_wstrb = 4'b1111;
        wait_cfg  = 4'd3;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("abandon noack", 32'(mem_ready), 32'h0);
        end
        txn("abandon rd", 32'h0000_0024, 32'h0, 4'b0000, 4'd0);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0)
                a = {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom)};
            else if (r == 1)
                a = {26'h0, 4'($urandom), 2'($urandom_range(1, 3))};
            else
                a = {26'h0, 4'($urandom), 2'b00};
            s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            txn("rand", a, $urandom, s, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 39) == 0) begin
                do_reset(1);
                check_eq("rand reset err", 32'(addr_err), 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
